rr_mux_select_arbiter: RTL and testbench



---
 rtl/rr_mux_select_arbiter_pkg.sv | 18 +
 rtl/rr_mux_select_arbiter_grant_rotator.sv | 37 +++
 rtl/rr_mux_select_arbiter.sv | 171 +++++++++++++++++
 tb/tb_rr_mux_select_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_select_arbiter_pkg.sv
// rr_mux_select_arbiter_pkg
//   Shared constants and types for the round-robin mux-select arbiter:
//   channel count, select width, output-stage state encoding and the
//   default data / counter widths used by the top level.
package rr_mux_select_arbiter_pkg;

  localparam int NUM_CH          = 4;
  localparam int SEL_W           = 2;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_COUNT_WIDTH = 16;

  // Output stage occupancy; FULL means out_data holds an undelivered word.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_mux_select_arbiter_grant_rotator.sv
// rr_grant_rotator
//   Combinational round-robin search. Scans in_valid starting at ptr and
//   wrapping 3->0; the first requesting channel found is the grant.
//   Ports:
//     in_valid     [3:0] per-channel requests
//     ptr          [1:0] highest-priority channel this cycle
//     grant_exists       at least one channel is requesting
//     g            [1:0] granted channel (equals ptr when nothing requests)
module rr_grant_rotator
  import rr_mux_select_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] in_valid,
  input  logic [SEL_W-1:0]  ptr,
  output logic              grant_exists,
  output logic [SEL_W-1:0]  g
);

  logic [SEL_W-1:0] idx_s;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_exists = 1'b0;
    g            = ptr;
    idx_s        = ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx_s = ptr + SEL_W'(k);  // 2-bit add wraps naturally mod 4
      if (in_valid[idx_s]) begin
        grant_exists = 1'b1;
        g            = idx_s;
      end else begin
        grant_exists = grant_exists;
        g            = g;
      end
    end
  end

endmodule

// File: rtl/rr_mux_select_arbiter.sv
// rr_mux_select_arbiter
//   Round-robin arbiter in front of a 32-bit 4:1 mux. Drives the mux
//   select, accepts one channel per cycle and registers the chosen word in
//   a single-entry valid/ready output stage (1-cycle latency, full rate).
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     in_valid/in_ready per-channel request / accept (one-hot accept)
//     in_data0..3       channel data words
//     sel               mux select (current grant, else last transferred)
//     out_valid/out_ready/out_data/out_chan  registered output stage
//     grant_count       saturating per-channel transfer counters, only
//                       when RR_ARB_STATS_EN is defined
module rr_mux_select_arbiter
  import rr_mux_select_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data0,
  input  logic [DATA_WIDTH-1:0]       in_data1,
  input  logic [DATA_WIDTH-1:0]       in_data2,
  input  logic [DATA_WIDTH-1:0]       in_data3,
  output logic [NUM_CH-1:0]           in_ready,
  output logic [SEL_W-1:0]            sel,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]            out_chan,
`ifdef RR_ARB_STATS_EN
  output logic [NUM_CH*COUNT_WIDTH-1:0] grant_count,
`endif
  input  logic                        out_ready
);

  out_state_e            state_q, state_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;
  logic [SEL_W-1:0]      last_sel_q, last_sel_d;
  logic [SEL_W-1:0]      out_chan_q, out_chan_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  grant_exists_s;
  logic [SEL_W-1:0]      g_s;
  logic                  accept_en_s;
  logic                  xfer_s;
  logic [NUM_CH-1:0]     in_ready_s;
  logic [DATA_WIDTH-1:0] mux_data_s;

  rr_grant_rotator u_rot (
    .in_valid     (in_valid),
    .ptr          (ptr_q),
    .grant_exists (grant_exists_s),
    .g            (g_s)
  );

  assign out_valid   = (state_q == ST_FULL);
  assign out_data    = out_data_q;
  assign out_chan    = out_chan_q;
  assign accept_en_s = !out_valid || out_ready;
  assign in_ready    = in_ready_s;
  assign xfer_s      = |(in_valid & in_ready_s);

  // One-hot accept for the granted channel; forced low while in reset.
  always_comb begin
    in_ready_s = {NUM_CH{1'b0}};
    if (!rst && accept_en_s && grant_exists_s) begin
      in_ready_s[g_s] = 1'b1;
    end else begin
      in_ready_s = {NUM_CH{1'b0}};
    end
  end

  // Mux select: live grant, otherwise hold the last transferred channel.
  always_comb begin
    if (rst) begin
      sel = {SEL_W{1'b0}};
    end else if (grant_exists_s) begin
      sel = g_s;
    end else begin
      sel = last_sel_q;
    end
  end

  // The 4:1 data mux feeding the output register.
  always_comb begin
    mux_data_s = in_data0;
    case (g_s)
      2'd0:    mux_data_s = in_data0;
      2'd1:    mux_data_s = in_data1;
      2'd2:    mux_data_s = in_data2;
      2'd3:    mux_data_s = in_data3;
      default: mux_data_s = in_data0;
    endcase
  end

  // Output stage next state: load on transfer (even while draining), else drain.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    last_sel_d = last_sel_q;
    out_chan_d = out_chan_q;
    out_data_d = out_data_q;
    if (xfer_s) begin
      state_d    = ST_FULL;
      ptr_d      = g_s + 2'd1;
      last_sel_d = g_s;
      out_chan_d = g_s;
      out_data_d = mux_data_s;
    end else if (out_valid && out_ready) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // Arbiter pointer and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= {SEL_W{1'b0}};
      last_sel_q <= {SEL_W{1'b0}};
      out_chan_q <= {SEL_W{1'b0}};
      out_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      last_sel_q <= last_sel_d;
      out_chan_q <= out_chan_d;
      out_data_q <= out_data_d;
    end
  end

`ifdef RR_ARB_STATS_EN
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  logic [NUM_CH-1:0][COUNT_WIDTH-1:0] cnt_q, cnt_d;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + COUNT_WIDTH'(1);
    end
  endfunction

  // Count transfers per channel, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer_s) begin
      cnt_d[g_s] = sat_inc(cnt_q[g_s]);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Grant counter storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt_out
    assign grant_count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// tb_rr_mux_select_arbiter
//   Scoreboard bench: the stimulus process predicts each accepted word with
//   a round-robin reference model and queues it; a separate monitor pops
//   and compares whenever the output stage hands a word downstream.
module tb_rr_mux_select_arbiter;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    in_valid = 4'b0000;
  logic [DW-1:0] in_data0 = '0, in_data1 = '0, in_data2 = '0, in_data3 = '0;
  logic          out_ready = 1'b0;
  logic [3:0]    in_ready;
  logic [1:0]    sel;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_chan;
`ifdef RR_ARB_STATS_EN
  logic [4*CW-1:0] grant_count;
`endif

  rr_mux_select_arbiter #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_ready(in_ready), .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_chan(out_chan),
`ifdef RR_ARB_STATS_EN
    .grant_count(grant_count),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; logic [1:0] chan; } exp_t;
  exp_t sbq[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_ptr  = 0;
  int m_last = 0;
  bit m_full = 0;
  int m_cnt[4] = '{0, 0, 0, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // First requesting channel at or after the pointer, wrapping; -1 if none.
  function automatic int model_grant(input logic [3:0] iv);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (iv[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_last = 0; m_full = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    sbq.delete();
  endtask

  task automatic cycle(input logic [3:0] iv, input logic ordy,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    logic [DW-1:0] dv[4];
    logic [3:0]    exp_ready;
    logic [1:0]    exp_sel;
    int            g;
    bit            accept;
    exp_t          e;
    @(negedge clk);
    in_valid = iv; out_ready = ordy;
    in_data0 = d0; in_data1 = d1; in_data2 = d2; in_data3 = d3;
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    #1;
    g = model_grant(iv);
    accept = !m_full || ordy;
    exp_ready = (accept && g >= 0) ? (4'b0001 << g) : 4'b0000;
    exp_sel = (g >= 0) ? 2'(g) : 2'(m_last);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("sel", 64'(sel), 64'(exp_sel));
    chk("out_valid", 64'(out_valid), 64'(m_full));
    if (accept && g >= 0) begin
      e.data = dv[g]; e.chan = 2'(g);
      sbq.push_back(e);
      m_ptr = (g + 1) % 4; m_last = g; m_full = 1;
      if (m_cnt[g] < CNT_MAX) m_cnt[g]++;
    end else if (m_full && ordy) begin
      m_full = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_chan", 64'(out_chan), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 4'b0000; out_ready = 1'b0;
  endtask

  // Monitor: compare each word as it is handed downstream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: got word %0h chan %0d expected none", out_data, out_chan);
        end else begin
          e = sbq.pop_front();
          chk("sb_data", 64'(out_data), 64'(e.data));
          chk("sb_chan", 64'(out_chan), 64'(e.chan));
        end
      end
    end
  end

  initial begin
    #1;
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_out_data", 64'(out_data), 64'd0);
    chk("init_in_ready", 64'(in_ready), 64'd0);
    chk("init_sel", 64'(sel), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // All-request rotation: 0,1,2,3,0
    for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b1, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    cycle(4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);

    // Wrap and skip: bring ptr to 3, then 0,2,0
    cycle(4'b0100, 1'b1, 32'h0, 32'h0, 32'hC2, 32'h0);
    for (int i = 0; i < 3; i++) cycle(4'b0101, 1'b1, 32'hD0 + i, 32'h0, 32'hD2 + i, 32'h0);
    cycle(4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);

    // Backpressure: hold a channel-1 word for 5 cycles, then drain and refill
    cycle(4'b0010, 1'b0, 32'h0, 32'hB1, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0010, 1'b0, 32'h0, 32'hB2, 32'h0, 32'h0);
      chk("bp_data_stable", 64'(out_data), 64'h000000B1);
    end
    cycle(4'b0010, 1'b1, 32'h0, 32'hB2, 32'h0, 32'h0);
    chk("refill_no_bubble", 64'(out_valid), 64'd1);

    // Dropped request: channel 2 waits under backpressure then withdraws
    cycle(4'b0100, 1'b0, 32'h0, 32'h0, 32'hE2, 32'h0);
    cycle(4'b0100, 1'b0, 32'h0, 32'h0, 32'hE2, 32'h0);
    cycle(4'b0001, 1'b1, 32'hE0, 32'h0, 32'h0, 32'h0);
    cycle(4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset mid-stream with a held word, then first grant goes to channel 0
    cycle(4'b1111, 1'b0, 32'h10, 32'h11, 32'h12, 32'h13);
    in_valid = 4'b1111;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(4'b1111, 1'b1, 32'hF0, 32'hF1, 32'hF2, 32'hF3);

    // Randomised traffic
    for (int i = 0; i < 2000; i++)
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom, $urandom);
    cycle(4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle(4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("sb_drained", 64'(sbq.size()), 64'd0);

`ifdef RR_ARB_STATS_EN
    for (int i = 0; i < 4; i++)
      chk("grant_count_rand", 64'(grant_count[i*CW +: CW]), 64'(m_cnt[i]));
    do_reset();
    for (int i = 0; i < 70000; i++) cycle(4'b0010, 1'b1, 32'h0, 32'(i), 32'h0, 32'h0);
    cycle(4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("grant_count_sat1", 64'(grant_count[1*CW +: CW]), 64'hFFFF);
    chk("grant_count_ch0", 64'(grant_count[0*CW +: CW]), 64'd0);
    chk("grant_count_ch2", 64'(grant_count[2*CW +: CW]), 64'd0);
    chk("grant_count_ch3", 64'(grant_count[3*CW +: CW]), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
